reg_grp_router: RTL and testbench

// - Parametrised CPU register-bus router; generalises the fixed four-target core/SRAM/UDP/DRAM register group.
// - Pops requests from the CPCI bus FIFO and decodes the word address to one of NUM_TARGETS equal address windows.
// - Runs a req/ack transaction to that target with timeout, then returns read data, completion ack and error status.
// - Sits between the CPCI register FIFO and the per-block register interfaces in nf2_core.

---
 rtl/reg_grp_router.sv | 225 ++++++++++++++++++++++
 tb/tb_reg_grp_router.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_grp_router.sv
// reg_grp_router: CPU register-bus router.
// Pops CPCI requests from the register FIFO and decodes the word address to one
// of NUM_TARGETS equal windows. It then runs a req/ack handshake with timeout and
// returns the read data, a completion ack and the error status.
// Optional feature macro: REG_GRP_TIMEOUT_LOG_EN. When it is defined, the router
// keeps the timeout address log (to_addr_log) and the saturating timeout counter
// (to_cnt). When it is undefined, both outputs read as 0.
module reg_grp_router #(
  parameter int                    ADDR_WIDTH     = 27,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_TARGETS    = 4,
  parameter int                    TGT_ADDR_WIDTH = 16,
  parameter int                    BASE_TAG       = 1,
  parameter int                    TIMEOUT        = 511,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  input  logic                              bus_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]             bus_addr,
  input  logic [DATA_WIDTH-1:0]             bus_wr_data,
  output logic [DATA_WIDTH-1:0]             bus_rd_data,
  output logic                              bus_rd_vld,
  output logic                              bus_rd_err,
  output logic                              out_ack,
  output logic [NUM_TARGETS-1:0]            tgt_req,
  output logic                              tgt_rd_wr_L,
  output logic [TGT_ADDR_WIDTH-1:0]         tgt_addr,
  output logic [DATA_WIDTH-1:0]             tgt_wr_data,
  input  logic [NUM_TARGETS-1:0]            tgt_ack,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] tgt_rd_data,
  output logic                              timeout_flag,
  input  logic                              clr_timeout,
  output logic [ADDR_WIDTH-3:0]             to_addr_log,
  output logic [15:0]                       to_cnt
);

  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int TAG_W = WA_W - TGT_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, GET_REQ, WAIT_ACK, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    rd_q, rd_d;
  logic [WA_W-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic                    hit_q, hit_d;
  logic [NUM_TARGETS-1:0]  req_q, req_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    timeout_flag_q, timeout_flag_d;
  logic                    to_evt;
  logic [NUM_TARGETS-1:0]  hit_vec;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    ack_sel;
  logic                    unused_ok;

  // Window decode: the tag bits above the per-target offset select the target.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (bus_addr[ADDR_WIDTH-1 -: TAG_W] == TAG_W'(BASE_TAG + i)) hit_vec[i] = 1'b1;
    end
  end

  // Read-data mux and ack qualification. Only the selected target counts.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (req_q[i]) rd_mux = rd_mux | tgt_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    ack_sel = |(tgt_ack & req_q);
  end

  // Transaction FSM: next state, FIFO pop, request latch, ack/timeout resolution.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    data_d     = data_q;
    err_d      = err_q;
    hit_d      = hit_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    to_evt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = GET_REQ;
        end
      end
      GET_REQ: begin
        rd_d      = bus_rd_wr_L;
        addr_d    = bus_addr[ADDR_WIDTH-1:2];
        wr_data_d = bus_rd_wr_L ? '0 : bus_wr_data;
        cnt_d     = 16'(TIMEOUT);
        hit_d     = |hit_vec;
        req_d     = hit_vec;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A miss spends this cycle with no request raised, so reads complete with
        // the same latency whether they hit or miss.
        if (!hit_q) begin
          err_d   = 1'b1;
          data_d  = ERR_DATA;
          state_d = RESP;
        end else if (ack_sel) begin
          // Ack beats a same-cycle expiry.
          data_d  = rd_mux;
          err_d   = 1'b0;
          req_d   = '0;
          state_d = RESP;
        end else if (cnt_q == 16'd0) begin
          err_d   = 1'b1;
          data_d  = ERR_DATA;
          req_d   = '0;
          to_evt  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESP: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = GET_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky timeout flag. A clear beats a same-cycle set.
  always_comb begin
    timeout_flag_d = timeout_flag_q;
    if (clr_timeout)  timeout_flag_d = 1'b0;
    else if (to_evt)  timeout_flag_d = 1'b1;
  end

  // State and datapath registers. Reset drops any open request at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rd_q           <= 1'b1;
      addr_q         <= '0;
      wr_data_q      <= '0;
      data_q         <= '0;
      err_q          <= 1'b0;
      hit_q          <= 1'b0;
      req_q          <= '0;
      cnt_q          <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      addr_q         <= addr_d;
      wr_data_q      <= wr_data_d;
      data_q         <= data_d;
      err_q          <= err_d;
      hit_q          <= hit_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

`ifdef REG_GRP_TIMEOUT_LOG_EN
  logic [WA_W-1:0] to_log_q, to_log_d;
  logic [15:0]     to_cnt_q, to_cnt_d;

  // Timeout log: last timed-out word address plus a saturating event count.
  always_comb begin
    to_log_d = to_log_q;
    to_cnt_d = to_cnt_q;
    if (clr_timeout) begin
      to_log_d = '0;
      to_cnt_d = '0;
    end else if (to_evt) begin
      to_log_d = addr_q;
      if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  // Timeout log registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_log_q <= '0;
      to_cnt_q <= '0;
    end else begin
      to_log_q <= to_log_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_addr_log = to_log_q;
  assign to_cnt      = to_cnt_q;
`else
  assign to_addr_log = '0;
  assign to_cnt      = '0;
`endif

  assign out_ack      = (state_q == RESP);
  assign bus_rd_vld   = (state_q == RESP) && rd_q;
  assign bus_rd_err   = (state_q == RESP) && err_q;
  assign bus_rd_data  = bus_rd_vld ? data_q : '0;
  assign tgt_req      = req_q;
  assign tgt_rd_wr_L  = rd_q;
  assign tgt_addr     = addr_q[TGT_ADDR_WIDTH-1:0];
  assign tgt_wr_data  = wr_data_q;
  assign timeout_flag = timeout_flag_q;

  // The byte-lane bits never matter. The tag bits of the latched address are
  // read only by the optional timeout log.
  assign unused_ok = ^{bus_addr[1:0], addr_q[WA_W-1:TGT_ADDR_WIDTH]};

endmodule

// File: tb/tb_reg_grp_router.sv
// Directed testbench for reg_grp_router with the default parameters.
module tb_reg_grp_router;

  localparam int TIMEOUT = 511;

  logic         clk;
  logic         reset_n;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic         bus_rd_wr_L;
  logic [26:0]  bus_addr;
  logic [31:0]  bus_wr_data;
  logic [31:0]  bus_rd_data;
  logic         bus_rd_vld;
  logic         bus_rd_err;
  logic         out_ack;
  logic [3:0]   tgt_req;
  logic         tgt_rd_wr_L;
  logic [15:0]  tgt_addr;
  logic [31:0]  tgt_wr_data;
  logic [3:0]   tgt_ack;
  logic [127:0] tgt_rd_data;
  logic         timeout_flag;
  logic         clr_timeout;
  logic [24:0]  to_addr_log;
  logic [15:0]  to_cnt;

  typedef struct {
    logic        rd;
    logic [26:0] addr;
    logic [31:0] data;
  } req_t;

  req_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   n;

  reg_grp_router dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .bus_rd_wr_L(bus_rd_wr_L), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rd_vld(bus_rd_vld), .bus_rd_err(bus_rd_err),
    .out_ack(out_ack), .tgt_req(tgt_req), .tgt_rd_wr_L(tgt_rd_wr_L), .tgt_addr(tgt_addr),
    .tgt_wr_data(tgt_wr_data), .tgt_ack(tgt_ack), .tgt_rd_data(tgt_rd_data),
    .timeout_flag(timeout_flag), .clr_timeout(clr_timeout), .to_addr_log(to_addr_log),
    .to_cnt(to_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rd, input logic [26:0] addr, input logic [31:0] data);
    req_t r;
    r.rd = rd; r.addr = addr; r.data = data;
    q.push_back(r);
    fifo_empty = 1'b0;
  endtask

  // One clock: the FIFO model presents the popped entry in the cycle after fifo_rd_en.
  task automatic tick();
    logic pop;
    req_t r;
    #1;
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) begin
      r = q.pop_front();
      bus_rd_wr_L = r.rd;
      bus_addr    = r.addr;
      bus_wr_data = r.data;
    end
    fifo_empty = (q.size() == 0);
  endtask

  // Counts the cycles with tgt_req raised. The selected target acks in cycle ack_at (1-based).
  task automatic serve(input int ack_at, input logic [3:0] mask, input logic [31:0] d,
                       output int cycles);
    cycles = 0;
    tgt_rd_data = {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000};
    while (tgt_req != 4'b0 && cycles < 2000) begin
      cycles++;
      if (cycles == ack_at) begin
        tgt_ack = mask;
        for (int i = 0; i < 4; i++) if (mask[i]) tgt_rd_data[i*32 +: 32] = d;
      end
      tick();
      tgt_ack = 4'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; fifo_empty = 1'b1; bus_rd_wr_L = 1'b1; bus_addr = '0;
    bus_wr_data = '0; tgt_ack = '0; tgt_rd_data = '0; clr_timeout = 1'b0;
    tick(); tick();
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    chk("rst_tgt_req", tgt_req, 0);
    chk("rst_tgt_rd_wr_L", tgt_rd_wr_L, 1);
    chk("rst_out_ack", out_ack, 0);
    chk("rst_rd_vld", bus_rd_vld, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    chk("rst_to_cnt", to_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Read target 2 at byte 0x0C0010, with the ack on the 4th request cycle.
    push(1'b1, 27'h00C0010, 32'h0);
    #1 chk("t1_pop_T0", fifo_rd_en, 1);
    tick();
    chk("t1_no_req_T1", tgt_req, 0);
    chk("t1_no_pop_T1", fifo_rd_en, 0);
    tick();
    chk("t1_req_T2", tgt_req, 4'b0100);
    chk("t1_tgt_addr", tgt_addr, 16'h0004);
    chk("t1_dir", tgt_rd_wr_L, 1);
    chk("t1_wr_data_zero", tgt_wr_data, 0);
    serve(4, 4'b0100, 32'h12345678, n);
    chk("t1_req_cycles", n, 4);
    chk("t1_out_ack", out_ack, 1);
    chk("t1_rd_vld", bus_rd_vld, 1);
    chk("t1_rd_data", bus_rd_data, 32'h12345678);
    chk("t1_rd_err", bus_rd_err, 0);
    tick();
    chk("t1_ack_pulse", out_ack, 0);
    chk("t1_vld_pulse", bus_rd_vld, 0);

    // Write to target 0 (word 0x10008) that never acks.
    push(1'b0, 27'h0040020, 32'hA5A50001);
    tick(); tick();
    chk("t2_req", tgt_req, 4'b0001);
    chk("t2_dir", tgt_rd_wr_L, 0);
    chk("t2_wr_data", tgt_wr_data, 32'hA5A50001);
    serve(0, 4'b0000, 32'h0, n);
    chk("t2_req_cycles", n, TIMEOUT + 1);
    chk("t2_out_ack", out_ack, 1);
    chk("t2_err", bus_rd_err, 1);
    chk("t2_no_vld", bus_rd_vld, 0);
    chk("t2_rd_data_zero", bus_rd_data, 0);
    chk("t2_flag", timeout_flag, 1);
`ifdef REG_GRP_TIMEOUT_LOG_EN
    chk("t2_to_cnt", to_cnt, 1);
    chk("t2_to_log", to_addr_log, 25'h0010008);
`else
    chk("t2_to_cnt", to_cnt, 0);
    chk("t2_to_log", to_addr_log, 0);
`endif
    tick();
    clr_timeout = 1'b1;
    tick();
    clr_timeout = 1'b0;
    chk("t2_flag_clr", timeout_flag, 0);
    chk("t2_cnt_clr", to_cnt, 0);

    // A read with tag 0 misses: no request, error data 3 cycles after the pop.
    push(1'b1, 27'h0000040, 32'h0);
    #1 chk("t3_pop_T0", fifo_rd_en, 1);
    tick(); tick();
    chk("t3_no_req", tgt_req, 0);
    chk("t3_no_ack_T2", out_ack, 0);
    tick();
    chk("t3_vld_T3", bus_rd_vld, 1);
    chk("t3_data", bus_rd_data, 32'hDEADBEEF);
    chk("t3_err", bus_rd_err, 1);
    tick();

    // Back to back: target 3 (the target 1 ack is ignored), then target 1.
    push(1'b1, 27'h0100008, 32'h0);
    push(1'b1, 27'h008000C, 32'h0);
    #1 chk("t4_pop_first", fifo_rd_en, 1);
    tick();
    chk("t4_no_pop_getreq", fifo_rd_en, 0);
    tick();
    chk("t4_req3", tgt_req, 4'b1000);
    chk("t4_addr3", tgt_addr, 16'h0002);
    tgt_rd_data = {32'hEEEE0003, 32'hEEEE0002, 32'hBAD00001, 32'hEEEE0000};
    tgt_ack = 4'b0010;
    tick();
    chk("t4_foreign_ack_ignored", tgt_req, 4'b1000);
    chk("t4_no_early_ack", out_ack, 0);
    tgt_ack = 4'b1000;
    tgt_rd_data[96 +: 32] = 32'h3333CAFE;
    tick();
    tgt_ack = 4'b0;
    chk("t4_first_data", bus_rd_data, 32'h3333CAFE);
    chk("t4_first_err", bus_rd_err, 0);
    chk("t4_pop_in_resp", fifo_rd_en, 1);
    tick();
    chk("t4_no_idle_gap", out_ack, 0);
    chk("t4_getreq_no_req", tgt_req, 0);
    tick();
    chk("t4_req1", tgt_req, 4'b0010);
    chk("t4_addr1", tgt_addr, 16'h0003);
    serve(1, 4'b0010, 32'h11110001, n);
    chk("t4_second_cycles", n, 1);
    chk("t4_second_vld", bus_rd_vld, 1);
    chk("t4_second_data", bus_rd_data, 32'h11110001);
    tick();

    // The ack arrives in the same cycle as the expiry, so the ack wins.
    push(1'b1, 27'h0040000, 32'h0);
    tick(); tick();
    serve(TIMEOUT + 1, 4'b0001, 32'h0BADF00D, n);
    chk("t5_cycles", n, TIMEOUT + 1);
    chk("t5_err", bus_rd_err, 0);
    chk("t5_data", bus_rd_data, 32'h0BADF00D);
    chk("t5_no_flag", timeout_flag, 0);
    tick();

    // Reset in the middle of WAIT_ACK drops the request; the next read runs normally.
    push(1'b1, 27'h0080000, 32'h0);
    tick(); tick(); tick();
    chk("t6_req_before_rst", tgt_req, 4'b0010);
    reset_n = 1'b0;
    #1 chk("t6_req_drop", tgt_req, 0);
    chk("t6_no_ack", out_ack, 0);
    tick();
    chk("t6_no_ack_held", out_ack, 0);
    reset_n = 1'b1;
    tick();
    chk("t6_no_ack_after", out_ack, 0);
    push(1'b1, 27'h00C0100, 32'h0);
    tick(); tick();
    chk("t6_addr", tgt_addr, 16'h0040);
    serve(1, 4'b0100, 32'h5555AAAA, n);
    chk("t6_cycles", n, 1);
    chk("t6_vld", bus_rd_vld, 1);
    chk("t6_data", bus_rd_data, 32'h5555AAAA);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
